// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Encodings shared by the memory-access stage and the units that sit around
// it: access sizes, memory-stage states and the writeback-source select
// values. It also holds two small helpers for size handling.
// -----------------------------------------------------------------------------
package mem_pkg;

    // Access size as carried on SIZE_i (log2 of the byte count)
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    // Memory-stage sequencing
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Writeback-source select consumed by the writeback unit. The stage
    // only carries this value through to WB_SEL.
    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_PC   = 2'd2,
        WB_LINK = 2'd3
    } wb_sel_e;

    // A 32-bit bus has no dword lane: a dword request behaves as a word.
    function automatic logic [1:0] eff_size(input logic [1:0] size, input int data_w);
        if ((data_w == 32) && (size == SZ_D))
            return SZ_W;
        return size;
    endfunction

    // Low-offset bits that must be zero for an access of this size to be aligned.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        return 3'((4'd1 << size) - 4'd1);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational byte-lane steering for the memory-access stage.
//   Store path: offset + size -> byte strobes, low bytes of store data
//               replicated across every lane of the bus.
//   Load path:  read data + offset + size + zero_ext -> field selected at the
//               offset and sign- or zero-extended to DATA_W.
// Ports:
//   off       in   byte offset within the bus word (already size-aligned)
//   size      in   effective access size (SZ_D never reaches a 32-bit bus)
//   zero_ext  in   1 = zero-extend the load field, 0 = sign-extend
//   st_data   in   store data (rt)
//   ld_data   in   raw read data from memory
//   wstrb     out  byte strobes
//   wdata     out  lane-replicated store data
//   ld_ext    out  aligned and extended load data
// -----------------------------------------------------------------------------
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] off,
    input  logic [1:0]                  size,
    input  logic                        zero_ext,
    input  logic [DATA_W-1:0]           st_data,
    input  logic [DATA_W-1:0]           ld_data,
    output logic [DATA_W/8-1:0]         wstrb,
    output logic [DATA_W-1:0]           wdata,
    output logic [DATA_W-1:0]           ld_ext
);

    localparam int STRB_W = DATA_W / 8;

    // ---------------- store path ----------------
    logic [STRB_W-1:0] strb_base;

    always_comb begin
        case (size)
            SZ_B:    strb_base = STRB_W'(8'h01);
            SZ_H:    strb_base = STRB_W'(8'h03);
            SZ_W:    strb_base = STRB_W'(8'h0F);
            default: strb_base = '1;
        endcase
    end

    assign wstrb = strb_base << off;

    // Each lane takes the store byte whose index is the lane number modulo
    // the access size, so any legal offset finds its data in place.
    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
            logic [7:0] lane_byte;
            always_comb begin
                case (size)
                    SZ_B:    lane_byte = st_data[7:0];
                    SZ_H:    lane_byte = st_data[(gi % 2)*8 +: 8];
                    SZ_W:    lane_byte = st_data[(gi % 4)*8 +: 8];
                    default: lane_byte = st_data[(gi % 8)*8 +: 8];
                endcase
            end
            assign wdata[gi*8 +: 8] = lane_byte;
        end
    endgenerate

    // ---------------- load path ----------------
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] field_mask;
    logic [DATA_W-1:0] sign_pos;
    logic              sign_bit;
    int                nbits;

    // Shift the addressed field down to bit 0, then build a mask for the
    // field width and a one-hot pointer at its top bit for the sign.
    always_comb begin
        shifted    = ld_data >> {off, 3'b000};
        nbits      = 8 << size;
        field_mask = '0;
        sign_pos   = '0;
        for (int i = 0; i < DATA_W; i++) begin
            field_mask[i] = (i < nbits);
            sign_pos[i]   = (i == nbits - 1);
        end
        sign_bit = ~zero_ext & (|(shifted & sign_pos));
        ld_ext   = (shifted & field_mask) | (sign_bit ? ~field_mask : '0);
    end

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Memory stage between EX and the writeback unit. Captures the EX bundle on
// acceptance, runs a request/grant/response data-memory transaction for loads
// and stores, and retires each instruction as a single registered wb_valid
// beat. Non-memory instructions retire the cycle after acceptance at one per
// cycle.
//
// Optional feature (macro MEM_ALIGN_CHK_EN):
//   defined   - a misaligned access issues no memory request and retires next
//               cycle with misalign=1, regWr=0.
//   undefined - misalign is tied 0; the lane offset is forced down to the
//               access-size alignment.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   EX handshake (in_ready low stalls EX)
//   memAddr_i..WB_SEL_i   EX bundle: address, store data, ALU result,
//                         destination, write enable, load/store, size,
//                         unsigned, writeback select
//   mem_req..mem_wstrb    data-memory request (held until mem_gnt)
//   mem_gnt, mem_rvalid,
//   mem_rdata             data-memory grant and read response
//   wb_valid..misalign    registered writeback beat
// -----------------------------------------------------------------------------
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int REG_AW  = 5,
    parameter int WBSEL_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   memAddr_i,
    input  logic [DATA_W-1:0]   memData_i,
    input  logic [DATA_W-1:0]   regcData_i,
    input  logic [REG_AW-1:0]   regcAddr_i,
    input  logic                regcWr_i,
    input  logic                R_MEM_EN_i,
    input  logic                W_MEM_EN_i,
    input  logic [1:0]          SIZE_i,
    input  logic                UNSIGNED_i,
    input  logic [WBSEL_W-1:0]  WB_SEL_i,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                wb_valid,
    output logic                regWr,
    output logic [REG_AW-1:0]   regAddr,
    output logic [DATA_W-1:0]   regData,
    output logic [WBSEL_W-1:0]  WB_SEL,
    output logic                misalign
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    // ---------------- state and holding register ----------------
    state_e              state_reg, state_next;
    logic                capture;

    logic [ADDR_W-1:0]   h_addr_reg;
    logic [DATA_W-1:0]   h_wdata_reg;
    logic [DATA_W-1:0]   h_rcdata_reg;
    logic [REG_AW-1:0]   h_rcaddr_reg;
    logic                h_rcwr_reg;
    logic                h_store_reg;
    logic                h_unsigned_reg;
    logic [1:0]          h_size_reg;
    logic [WBSEL_W-1:0]  h_wbsel_reg;

    // ---------------- writeback registers ----------------
    logic                wb_valid_reg,  wb_valid_next;
    logic                reg_wr_reg,    reg_wr_next;
    logic [REG_AW-1:0]   reg_addr_reg,  reg_addr_next;
    logic [DATA_W-1:0]   reg_data_reg,  reg_data_next;
    logic [WBSEL_W-1:0]  wb_sel_reg,    wb_sel_next;
    logic                misalign_reg,  misalign_next;

    // ---------------- input decode ----------------
    logic       in_is_mem;
    logic       in_misalign;
    logic [1:0] in_size;

    assign in_is_mem = R_MEM_EN_i | W_MEM_EN_i;
    assign in_size   = eff_size(SIZE_i, DATA_W);

`ifdef MEM_ALIGN_CHK_EN
    logic [2:0] in_off;
    assign in_off      = 3'(memAddr_i[OFF_W-1:0]);
    assign in_misalign = in_is_mem && ((in_off & align_mask(in_size)) != 3'd0);
`else
    assign in_misalign = 1'b0;
`endif

    // ---------------- lane steering ----------------
    logic [OFF_W-1:0]  off_eff;
    logic [STRB_W-1:0] lane_wstrb;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] load_ext;

`ifdef MEM_ALIGN_CHK_EN
    // Misaligned accesses never reach REQ, so the held offset is already aligned.
    assign off_eff = h_addr_reg[OFF_W-1:0];
`else
    assign off_eff = h_addr_reg[OFF_W-1:0] & ~OFF_W'(align_mask(h_size_reg));
`endif

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .off      (off_eff),
        .size     (h_size_reg),
        .zero_ext (h_unsigned_reg),
        .st_data  (h_wdata_reg),
        .ld_data  (mem_rdata),
        .wstrb    (lane_wstrb),
        .wdata    (lane_wdata),
        .ld_ext   (load_ext)
    );

    // ---------------- memory port ----------------
    // Driven straight from the state register so the request drops the
    // moment reset is asserted, and every field is zero while idle.
    assign in_ready  = (state_reg == S_IDLE);
    assign mem_req   = (state_reg == S_REQ);
    assign mem_we    = mem_req & h_store_reg;
    assign mem_addr  = mem_req ? {h_addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign mem_wdata = mem_req ? lane_wdata : '0;
    assign mem_wstrb = mem_req ? lane_wstrb : '0;

    // ---------------- next state / writeback ----------------
    always_comb begin
        state_next    = state_reg;
        capture       = 1'b0;
        wb_valid_next = 1'b0;
        reg_wr_next   = 1'b0;
        misalign_next = 1'b0;
        reg_addr_next = reg_addr_reg;
        reg_data_next = reg_data_reg;
        wb_sel_next   = wb_sel_reg;

        case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    capture = 1'b1;
                    if (in_misalign) begin
                        wb_valid_next = 1'b1;
                        misalign_next = 1'b1;
                        reg_addr_next = regcAddr_i;
                        reg_data_next = regcData_i;
                        wb_sel_next   = WB_SEL_i;
                    end else if (in_is_mem) begin
                        state_next = S_REQ;
                    end else begin
                        wb_valid_next = 1'b1;
                        reg_wr_next   = regcWr_i;
                        reg_addr_next = regcAddr_i;
                        reg_data_next = regcData_i;
                        wb_sel_next   = WB_SEL_i;
                    end
                end
            end

            S_REQ: begin
                if (mem_gnt) begin
                    if (h_store_reg) begin
                        state_next    = S_IDLE;
                        wb_valid_next = 1'b1;
                        reg_addr_next = h_rcaddr_reg;
                        reg_data_next = h_rcdata_reg;
                        wb_sel_next   = h_wbsel_reg;
                    end else if (mem_rvalid) begin
                        state_next    = S_IDLE;
                        wb_valid_next = 1'b1;
                        reg_wr_next   = h_rcwr_reg;
                        reg_addr_next = h_rcaddr_reg;
                        reg_data_next = load_ext;
                        wb_sel_next   = h_wbsel_reg;
                    end else begin
                        state_next = S_RESP;
                    end
                end
            end

            S_RESP: begin
                if (mem_rvalid) begin
                    state_next    = S_IDLE;
                    wb_valid_next = 1'b1;
                    reg_wr_next   = h_rcwr_reg;
                    reg_addr_next = h_rcaddr_reg;
                    reg_data_next = load_ext;
                    wb_sel_next   = h_wbsel_reg;
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            wb_valid_reg <= 1'b0;
            reg_wr_reg   <= 1'b0;
            reg_addr_reg <= '0;
            reg_data_reg <= '0;
            wb_sel_reg   <= '0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wb_valid_reg <= wb_valid_next;
            reg_wr_reg   <= reg_wr_next;
            reg_addr_reg <= reg_addr_next;
            reg_data_reg <= reg_data_next;
            wb_sel_reg   <= wb_sel_next;
            misalign_reg <= misalign_next;
        end
    end

    // Store beats load when both enables are set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_addr_reg     <= '0;
            h_wdata_reg    <= '0;
            h_rcdata_reg   <= '0;
            h_rcaddr_reg   <= '0;
            h_rcwr_reg     <= 1'b0;
            h_store_reg    <= 1'b0;
            h_unsigned_reg <= 1'b0;
            h_size_reg     <= 2'd0;
            h_wbsel_reg    <= '0;
        end else if (capture) begin
            h_addr_reg     <= memAddr_i;
            h_wdata_reg    <= memData_i;
            h_rcdata_reg   <= regcData_i;
            h_rcaddr_reg   <= regcAddr_i;
            h_rcwr_reg     <= regcWr_i;
            h_store_reg    <= W_MEM_EN_i;
            h_unsigned_reg <= UNSIGNED_i;
            h_size_reg     <= in_size;
            h_wbsel_reg    <= WB_SEL_i;
        end
    end

    assign wb_valid = wb_valid_reg;
    assign regWr    = reg_wr_reg;
    assign regAddr  = reg_addr_reg;
    assign regData  = reg_data_reg;
    assign WB_SEL   = wb_sel_reg;
    assign misalign = misalign_reg;

endmodule
